// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, parity modes, default oversample ratio.
// Pure declarations, no logic, so no latency or flow-control behaviour.
package uart_pkg;

   typedef enum logic [2:0] {
      WAIT_HIGH,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   localparam int OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous bit, with a selectable reset value.
// Latency 2 UCLK; no flow control, the input is sampled every cycle.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic UCLK,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge UCLK) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: one word plus framing/parity status per frame; done pulses 1 UCLK after the stop-bit sample.
// Never stalls and has no ready input; the consumer must accept each rx_done_tick or lose the word.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
   parameter int PARITY_MODE = PARITY_NONE
) (
   input  logic                  UCLK,
   input  logic                  reset,
   input  logic                  s_tick,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] rx_dout,
   output logic                  rx_done_tick,
   output logic                  frame_err,
   output logic                  parity_err
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);
   localparam logic          PAR_EXP = (PARITY_MODE == PARITY_ODD);

   logic                  rx_s;
   rx_state_t             state_q, state_n;
   logic [SW-1:0]         s_cnt_q, s_cnt_n;
   logic [NW-1:0]         n_cnt_q, n_cnt_n;
   logic [DATA_WIDTH-1:0] sh_q, sh_n;
   logic                  par_q, par_n;
   logic                  perr_q, perr_n;
   logic [DATA_WIDTH-1:0] dout_q, dout_n;
   logic                  done_q, done_n;
   logic                  ferr_q, ferr_n;
   logic                  perr_o_q, perr_o_n;

   // Resetting to 0 forces a genuine idle-high line to be seen before any start bit.
   uart_sync2 #(.RESET_VAL(1'b0)) u_sync_rx (
      .UCLK  (UCLK),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge UCLK) begin
      if (reset) begin
         state_q  <= WAIT_HIGH;
         s_cnt_q  <= '0;
         n_cnt_q  <= '0;
         sh_q     <= '0;
         par_q    <= 1'b0;
         perr_q   <= 1'b0;
         dout_q   <= '0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
         perr_o_q <= 1'b0;
      end else begin
         state_q  <= state_n;
         s_cnt_q  <= s_cnt_n;
         n_cnt_q  <= n_cnt_n;
         sh_q     <= sh_n;
         par_q    <= par_n;
         perr_q   <= perr_n;
         dout_q   <= dout_n;
         done_q   <= done_n;
         ferr_q   <= ferr_n;
         perr_o_q <= perr_o_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      s_cnt_n  = s_cnt_q;
      n_cnt_n  = n_cnt_q;
      sh_n     = sh_q;
      par_n    = par_q;
      perr_n   = perr_q;
      dout_n   = dout_q;
      done_n   = 1'b0;
      ferr_n   = ferr_q;
      perr_o_n = perr_o_q;
      case (state_q)
         WAIT_HIGH: begin
            if (rx_s) state_n = IDLE;
         end
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               s_cnt_n = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_cnt_q == S_HALF) begin
                  // A line that is high again at mid start bit was only a glitch.
                  if (!rx_s) begin
                     state_n = DATA;
                     s_cnt_n = '0;
                     n_cnt_n = '0;
                     par_n   = 1'b0;
                     perr_n  = 1'b0;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  s_cnt_n = s_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_cnt_q == S_LAST) begin
                  sh_n    = DATA_WIDTH'({rx_s, sh_q} >> 1);
                  par_n   = par_q ^ rx_s;
                  s_cnt_n = '0;
                  if (n_cnt_q == N_LAST)
                     state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                  else
                     n_cnt_n = n_cnt_q + 1'b1;
               end else begin
                  s_cnt_n = s_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s_cnt_q == S_LAST) begin
                  perr_n  = ((par_q ^ rx_s) != PAR_EXP);
                  s_cnt_n = '0;
                  state_n = STOP;
               end else begin
                  s_cnt_n = s_cnt_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_cnt_q == S_LAST) begin
                  dout_n   = sh_q;
                  done_n   = 1'b1;
                  ferr_n   = ~rx_s;
                  perr_o_n = perr_q;
                  s_cnt_n  = '0;
                  // A low stop bit may be a break; wait for idle before hunting a start.
                  state_n  = rx_s ? IDLE : WAIT_HIGH;
               end else begin
                  s_cnt_n = s_cnt_q + 1'b1;
               end
            end
         end
         default: state_n = WAIT_HIGH;
      endcase
   end

   assign rx_dout      = dout_q;
   assign rx_done_tick = done_q;
   assign frame_err    = ferr_q;
   assign parity_err   = perr_o_q;

endmodule
